// File: rtl/jml_reg_pkg.sv
// Shared types and default widths for the register-file arbiter.
package jml_reg_pkg;

  localparam int unsigned DefaultAw = 6;
  localparam int unsigned DefaultDw = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIWr,
    StIRd,
    StICap,
    StHWr,
    StHRd,
    StHCap
  } arb_state_t;

endpackage

// File: rtl/jml_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module jml_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the input through the synchronizer chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/jml_reg_arb.sv
// Arbitrates a register file between an I2C bridge (scl domain) and a local host.
module jml_reg_arb
  import jml_reg_pkg::*;
#(
  parameter int unsigned AW          = DefaultAw,
  parameter int unsigned DW          = DefaultDw,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] i2c_addr,
  input  logic          i2c_read,
  input  logic          i2c_write,
  input  logic [DW-1:0] i2c_write_data,
  output logic [DW-1:0] i2c_read_data,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] reg_addr,
  output logic          reg_wr,
  output logic          reg_rd,
  output logic [DW-1:0] reg_wdata,
  input  logic [DW-1:0] reg_rdata,
  output logic          ovf_err
);

  localparam int unsigned SW = AW + DW + 2;

  logic [SW-1:0] sync_in, sync_out;
  logic          rd_s, wr_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s;

  assign sync_in = {i2c_read, i2c_write, i2c_addr, i2c_write_data};

  for (genvar gi = 0; gi < SW; gi++) begin : g_sync
    jml_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i (clk),
      .rst_ni(reset_n),
      .d_i   (sync_in[gi]),
      .q_o   (sync_out[gi])
    );
  end

  assign {rd_s, wr_s, addr_s, wdata_s} = sync_out;

  arb_state_t    state_q, state_d;
  logic          wr_prev_q, rd_prev_q;
  logic [AW-1:0] addr_prev_q;
  logic          wr_pend_q, rd_pend_q, last_host_q, ovf_q;
  logic [AW-1:0] hold_addr_q, reg_addr_q;
  logic [DW-1:0] hold_data_q, reg_wdata_q, i2c_rdata_q, host_rdata_q;

  logic          wr_edge, rd_evt, wr_req, rd_req;
  logic          gnt_iwr, gnt_ird, gnt_hwr, gnt_hrd;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  // Events are folded into the request in the cycle they appear so that an edge
  // coinciding with a host request still wins arbitration.
  assign wr_edge = wr_s & ~wr_prev_q;
  assign rd_evt  = rd_s & (~rd_prev_q | (addr_s != addr_prev_q));
  assign wr_req  = wr_pend_q | wr_edge;
  assign rd_req  = rd_pend_q | rd_evt;
  assign wr_addr = wr_edge ? addr_s : hold_addr_q;
  assign wr_data = wr_edge ? wdata_s : hold_data_q;

  assign gnt_iwr = (state_q == StIdle) && (state_d == StIWr);
  assign gnt_ird = (state_q == StIdle) && (state_d == StIRd);
  assign gnt_hwr = (state_q == StIdle) && (state_d == StHWr);
  assign gnt_hrd = (state_q == StIdle) && (state_d == StHRd);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: prioritised arbitration in idle, fixed sequencing elsewhere
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          state_d = StIWr;
        end else if (rd_req && (last_host_q || !host_req)) begin
          state_d = StIRd;
        end else if (host_req) begin
          state_d = host_we ? StHWr : StHRd;
        end
      end
      StIRd:   state_d = StICap;
      StHRd:   state_d = StHCap;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    reg_wr     = 1'b0;
    reg_rd     = 1'b0;
    host_gnt   = 1'b0;
    host_rdata = host_rdata_q;
    unique case (state_q)
      StIWr: reg_wr = 1'b1;
      StIRd: reg_rd = 1'b1;
      StHWr: begin
        reg_wr   = 1'b1;
        host_gnt = 1'b1;
      end
      StHRd: reg_rd = 1'b1;
      StHCap: begin
        host_gnt   = 1'b1;
        host_rdata = reg_rdata;
      end
      default: ;
    endcase
  end

  // Edge history, pending flags, holding register and access address/data capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev_q    <= 1'b0;
      rd_prev_q    <= 1'b0;
      addr_prev_q  <= '0;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      last_host_q  <= 1'b0;
      ovf_q        <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      i2c_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      wr_prev_q   <= wr_s;
      rd_prev_q   <= rd_s;
      addr_prev_q <= addr_s;
      if (wr_edge) begin
        hold_addr_q <= addr_s;
        hold_data_q <= wdata_s;
      end
      // A new edge over an unserved write displaces it
      if (wr_edge && wr_pend_q) begin
        ovf_q <= 1'b1;
      end
      wr_pend_q <= gnt_iwr ? 1'b0 : wr_req;
      rd_pend_q <= gnt_ird ? 1'b0 : rd_req;
      if (gnt_iwr) begin
        reg_addr_q  <= wr_addr;
        reg_wdata_q <= wr_data;
        last_host_q <= 1'b0;
      end
      if (gnt_ird) begin
        reg_addr_q  <= addr_s;
        last_host_q <= 1'b0;
      end
      if (gnt_hwr) begin
        reg_addr_q  <= host_addr;
        reg_wdata_q <= host_wdata;
        last_host_q <= 1'b1;
      end
      if (gnt_hrd) begin
        reg_addr_q  <= host_addr;
        last_host_q <= 1'b1;
      end
      if (state_q == StICap) begin
        i2c_rdata_q <= reg_rdata;
      end
      if (state_q == StHCap) begin
        host_rdata_q <= reg_rdata;
      end
    end
  end

  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign i2c_read_data = i2c_rdata_q;
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_jml_reg_arb.sv
// Self-checking bench for jml_reg_arb: register-file model plus transaction scoreboard.
module tb_jml_reg_arb;

  localparam int WrLat = 1 + 2 + 1 + 3;

  typedef struct {
    logic [5:0] wa;
    logic [7:0] wd;
    int         wc;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [5:0] i2c_addr = '0;
  logic       i2c_read = 1'b0;
  logic       i2c_write = 1'b0;
  logic [7:0] i2c_write_data = '0;
  logic [7:0] i2c_read_data;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [5:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic [5:0] reg_addr;
  logic       reg_wr, reg_rd;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = '0;
  logic       ovf_err;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model state
  logic [7:0] mem_m [64];
  wr_t        i2c_wq[$];
  int         wlog[$];
  logic       m_ovf = 1'b0;
  logic       h_active = 1'b0;
  logic       h_we = 1'b0;
  logic [5:0] h_addr = '0;
  logic [7:0] h_wdata = '0;
  int         n_i2c_wr = 0;
  int         n_i2c_rd = 0;
  int         n_hgnt = 0;
  logic       stop = 1'b0;

  // Environment register file
  logic [7:0] rf [64];
  logic       rf_init = 1'b0;

  jml_reg_arb #(
    .AW(6),
    .DW(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i2c_addr      (i2c_addr),
    .i2c_read      (i2c_read),
    .i2c_write     (i2c_write),
    .i2c_write_data(i2c_write_data),
    .i2c_read_data (i2c_read_data),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_gnt      (host_gnt),
    .host_rdata    (host_rdata),
    .reg_addr      (reg_addr),
    .reg_wr        (reg_wr),
    .reg_rd        (reg_rd),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .ovf_err       (ovf_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    if (i == 16) return 8'h3C;
    if (i == 17) return 8'h7E;
    return 8'(i * 29 + 7);
  endfunction

  always @(posedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 64; i++) rf[i] <= init_val(i);
      rf_init <= 1'b1;
    end else begin
      if (reg_wr) rf[reg_addr] <= reg_wdata;
      if (reg_rd) reg_rdata <= rf[reg_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " reg_wr"}, reg_wr, 0);
    check({tag, " reg_rd"}, reg_rd, 0);
    check({tag, " reg_addr"}, reg_addr, 0);
    check({tag, " reg_wdata"}, reg_wdata, 0);
    check({tag, " host_gnt"}, host_gnt, 0);
    check({tag, " host_rdata"}, host_rdata, 0);
    check({tag, " i2c_read_data"}, i2c_read_data, 0);
    check({tag, " ovf_err"}, ovf_err, 0);
  endtask

  task automatic host_access(input logic we, input logic [5:0] a, input logic [7:0] d);
    logic got;
    @(negedge clk);
    h_we = we;
    h_addr = a;
    h_wdata = d;
    h_active = 1'b1;
    host_req = 1'b1;
    host_we = we;
    host_addr = a;
    host_wdata = d;
    got = 1'b0;
    for (int w = 0; w < 60; w++) begin
      @(negedge clk);
      if (host_gnt) begin
        got = 1'b1;
        break;
      end
    end
    check("host_gnt within budget", got, 1);
    host_req = 1'b0;
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [7:0] d);
    wr_t e;
    e.wa = a;
    e.wd = d;
    e.wc = cyc;
    i2c_wq.push_back(e);
  endtask

  task automatic i2c_wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    i2c_addr = a;
    i2c_write_data = d;
    i2c_write = 1'b1;
    push_wr(a, d);
    repeat (16) @(negedge clk);
    i2c_write = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  // Scoreboard: every cycle, classify observed accesses and compare with the model
  initial begin : compare
    logic       prev_rd;
    logic [5:0] prev_addr;
    logic       pend_chk;
    logic [5:0] pend_addr;
    int         idx;
    int         lat;
    prev_rd = 1'b0;
    prev_addr = '0;
    pend_chk = 1'b0;
    pend_addr = '0;
    for (int i = 0; i < 64; i++) mem_m[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_rd = 1'b0;
        pend_chk = 1'b0;
      end else begin
        if (pend_chk) begin
          check("i2c_read_data", i2c_read_data, mem_m[pend_addr]);
          pend_chk = 1'b0;
        end
        if (reg_wr || reg_rd) check("strobe exclusive", reg_wr & reg_rd, 0);
        if (host_gnt) begin
          check("host_gnt requested", h_active, 1);
          check("host access kind", reg_wr, h_we);
          if (reg_wr) begin
            check("host wr addr", reg_addr, h_addr);
            check("host wr data", reg_wdata, h_wdata);
            mem_m[h_addr] = h_wdata;
            wlog.push_back(256 + int'(h_addr));
          end else begin
            check("host rd strobe before gnt", prev_rd, 1);
            check("host rd addr", prev_addr, h_addr);
            check("host_rdata", host_rdata, mem_m[h_addr]);
          end
          h_active = 1'b0;
          n_hgnt++;
        end else begin
          if (reg_wr) begin
            idx = -1;
            for (int k = 0; k < i2c_wq.size(); k++) begin
              if (i2c_wq[k].wa == reg_addr && i2c_wq[k].wd == reg_wdata) begin
                idx = k;
                break;
              end
            end
            n_tests++;
            if (idx < 0) begin
              n_fail++;
              $display("FAIL i2c write: got addr 0x%0h data 0x%0h, required a queued write",
                       reg_addr, reg_wdata);
            end else begin
              lat = cyc - i2c_wq[idx].wc;
              if (lat > WrLat) begin
                n_fail++;
                $display("FAIL i2c write latency: got %0d cycles, required <= %0d", lat, WrLat);
              end
              if (idx > 0) m_ovf = 1'b1;
              mem_m[reg_addr] = reg_wdata;
              repeat (idx + 1) void'(i2c_wq.pop_front());
              wlog.push_back(int'(reg_addr));
              n_i2c_wr++;
            end
          end
          if (prev_rd) begin
            check("i2c rd addr", prev_addr, i2c_addr);
            pend_chk = 1'b1;
            pend_addr = prev_addr;
            n_i2c_rd++;
          end
        end
        prev_rd = reg_rd;
        prev_addr = reg_addr;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    int base_wr, base_rd, base_h;
    #2 reset_n = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single I2C write
    base_wr = n_i2c_wr;
    i2c_wr(6'h05, 8'hA5);
    check("i2c write count", n_i2c_wr - base_wr, 1);
    check("model reg 0x05", mem_m[5], 8'hA5);
    check("ovf after single write", ovf_err, 0);

    // I2C read then address change refetch
    base_rd = n_i2c_rd;
    @(negedge clk);
    i2c_addr = 6'h10;
    i2c_read = 1'b1;
    repeat (12) @(negedge clk);
    check("i2c read 0x10", i2c_read_data, 8'h3C);
    i2c_addr = 6'h11;
    repeat (12) @(negedge clk);
    check("i2c read 0x11", i2c_read_data, 8'h7E);
    check("i2c fetch count", n_i2c_rd - base_rd, 2);
    i2c_read = 1'b0;
    repeat (8) @(negedge clk);

    // Host write colliding with a synchronized I2C write edge
    wlog.delete();
    base_h = n_hgnt;
    fork
      i2c_wr(6'h01, 8'h99);
      begin
        @(negedge clk);
        @(negedge clk);
        host_access(1'b1, 6'h22, 8'h55);
      end
    join
    check("collision write count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("first write is i2c 0x01", wlog[0], 32'h001);
      check("second write is host 0x22", wlog[1], 32'h122);
    end
    check("collision host_gnt count", n_hgnt - base_h, 1);
    check("ovf after collision", ovf_err, m_ovf);

    // Two I2C write edges while a host read occupies the arbiter
    repeat (10) @(negedge clk);
    base_wr = n_i2c_wr;
    @(negedge clk);
    i2c_addr = 6'h08;
    i2c_write_data = 8'h5A;
    i2c_write = 1'b1;
    push_wr(6'h08, 8'h5A);
    fork
      host_access(1'b0, 6'h11, 8'h00);
      begin
        @(negedge clk);
        i2c_write = 1'b0;
        @(negedge clk);
        i2c_write_data = 8'hC3;
        i2c_write = 1'b1;
        push_wr(6'h08, 8'hC3);
        @(negedge clk);
        i2c_write = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("overrun write count", n_i2c_wr - base_wr, 1);
    check("model saw lost write", m_ovf, 1);
    check("ovf_err set", ovf_err, 1);
    host_access(1'b0, 6'h08, 8'h00);
    check("overrun survivor data", host_rdata, 8'hC3);
    repeat (20) @(negedge clk);
    check("ovf_err sticky", ovf_err, 1);

    // Continuous host reads of 0x00 against recurring I2C read events
    base_rd = n_i2c_rd;
    base_h = n_hgnt;
    stop = 1'b0;
    fork
      begin
        while (!stop) host_access(1'b0, 6'h00, 8'h00);
      end
      begin
        @(negedge clk);
        i2c_addr = 6'h12;
        i2c_read = 1'b1;
        repeat (10) begin
          repeat (8) @(negedge clk);
          i2c_addr = i2c_addr + 6'd1;
        end
        repeat (8) @(negedge clk);
        stop = 1'b1;
      end
    join
    i2c_read = 1'b0;
    check("i2c reads served", n_i2c_rd - base_rd, 11);
    check("host reads progressed", (n_hgnt - base_h) >= 9, 1);
    check("total accesses >= 20", (n_hgnt - base_h + n_i2c_rd - base_rd) >= 20, 1);
    repeat (10) @(negedge clk);

    // Reset during a host read
    @(negedge clk);
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 6'h11;
    h_we = 1'b0;
    h_addr = 6'h11;
    h_active = 1'b1;
    @(negedge clk);
    check("host read strobe before reset", reg_rd, 1);
    reset_n = 1'b0;
    host_req = 1'b0;
    h_active = 1'b0;
    m_ovf = 1'b0;
    #1 check_zero("mid-access reset");
    @(negedge clk);
    check_zero("held reset");
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no gnt after abort", host_gnt, 0);
    end
    host_access(1'b0, 6'h11, 8'h00);
    check("fresh host read", host_rdata, 8'h7E);
    check("ovf after reset", ovf_err, m_ovf);

    repeat (5) @(negedge clk);
    check("i2c writes all accounted", i2c_wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
